// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect/stall controls from downstream, instruction memory
// address/data, and the IF/ID register outputs toward decode.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_instruction;
  logic [31:0] imem_pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  // Environment side: drives controls and returns the instruction word.
  modport master (
    output stall, branch_taken, branch_target, jump, jump_index, imem_instruction,
    input  imem_pc, if_id_instruction, if_id_pc_plus4, if_id_valid, halted, fetch_count
  );

  // Fetch stage side.
  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_index, imem_instruction,
    output imem_pc, if_id_instruction, if_id_pc_plus4, if_id_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter, IF/ID pipeline register, redirect with squash,
// and a sticky halt on the sentinel word.
//
// state   | meaning
// S_RUN   | fetching; redirect > stall > normal fetch each edge
// S_HALT  | sentinel fetched; all state frozen until reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned PC_INC    = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic    clock,
  input  logic    reset,
  fetch_if.slave  bus
);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus;
  logic [31:0] jump_target;
  logic        redirect;
  logic [31:0] redirect_target;

  assign pc_plus         = pc_q + 32'(PC_INC);
  assign jump_target     = {pc_plus[31:28], bus.jump_index, 2'b00};
  assign redirect        = bus.jump | bus.branch_taken;
  assign redirect_target = bus.jump ? jump_target : bus.branch_target;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    unique case (state_q)
      S_HALT: ;
      S_RUN: begin
        if (redirect) begin
          // The word currently at pc is squashed, so it is never halt-checked.
          pc_d    = redirect_target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (bus.imem_instruction == HALT_WORD) begin
          state_d = S_HALT;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          pc_d       = pc_plus;
          instr_d    = bus.imem_instruction;
          pc_plus4_d = pc_plus;
          valid_d    = 1'b1;
          count_d    = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'h1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign bus.imem_pc           = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc_plus4    = pc_plus4_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.halted            = (state_q == S_HALT);
  assign bus.fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus pushes expected IF/ID words into a queue;
// a negedge monitor pops and compares each new delivery.
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_if bus();
  fetch_stage dut (.clock(clock), .reset(reset), .bus(bus));

  logic [31:0] imem [0:63];
  assign bus.imem_instruction = imem[bus.imem_pc[7:2]];

  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] last_cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(logic [31:0] instr, logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  always @(negedge clock) begin
    if (reset) last_cnt = 32'h0;
    else if (bus.if_id_valid === 1'b1 && bus.fetch_count !== last_cnt) begin
      exp_t e;
      last_cnt = bus.fetch_count;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_delivery: got %h with no expected word", bus.if_id_instruction);
      end else begin
        e = exp_q.pop_front();
        check("ifid_instr", bus.if_id_instruction, e.instr);
        check("ifid_pc4", bus.if_id_pc_plus4, e.pc4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h2000_0000 + 32'(i) + 32'h1;
    imem[4] = 32'hFFFF_FFFF;
    reset = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.jump = 1'b0; bus.jump_index = 26'h0;

    tick(); tick();
    check("rst_pc", bus.imem_pc, 32'h0);
    check("rst_valid", 32'(bus.if_id_valid), 32'h0);
    check("rst_instr", bus.if_id_instruction, 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_count", bus.fetch_count, 32'h0);

    // sequential fetch
    push(32'h2000_0001, 32'h4);
    push(32'h2000_0002, 32'h8);
    reset = 1'b0;
    tick();
    check("seq_pc1", bus.imem_pc, 32'h4);
    tick();
    check("seq_pc2", bus.imem_pc, 32'h8);
    check("seq_count", bus.fetch_count, 32'd2);

    // stall
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.imem_pc, 32'h8);
      check("stall_instr", bus.if_id_instruction, 32'h2000_0002);
      check("stall_count", bus.fetch_count, 32'd2);
    end
    bus.stall = 1'b0;
    push(32'h2000_0003, 32'hC);
    tick();
    check("unstall_pc", bus.imem_pc, 32'hC);
    check("unstall_count", bus.fetch_count, 32'd3);

    // branch overrides stall
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40; bus.stall = 1'b1;
    tick();
    check("br_pc", bus.imem_pc, 32'h40);
    check("br_valid", 32'(bus.if_id_valid), 32'h0);
    check("br_instr", bus.if_id_instruction, 32'h0);
    check("br_count", bus.fetch_count, 32'd3);

    // jump wins over branch
    bus.jump = 1'b1; bus.jump_index = 26'h10; bus.branch_target = 32'h80; bus.stall = 1'b0;
    tick();
    check("jmp_pc", bus.imem_pc, 32'h40);
    check("jmp_valid", 32'(bus.if_id_valid), 32'h0);
    bus.jump = 1'b0; bus.branch_taken = 1'b0;

    push(32'h2000_0011, 32'h44);
    push(32'h2000_0012, 32'h48);
    push(32'h2000_0013, 32'h4C);
    push(32'h2000_0014, 32'h50);
    tick();
    check("post_redir_valid", 32'(bus.if_id_valid), 32'h1);
    tick(); tick(); tick();
    check("run_pc", bus.imem_pc, 32'h50);
    check("run_count", bus.fetch_count, 32'd7);

    // halt
    bus.branch_taken = 1'b1; bus.branch_target = 32'h10;
    tick();
    check("to_halt_pc", bus.imem_pc, 32'h10);
    bus.branch_taken = 1'b0;
    tick();
    check("halt_flag", 32'(bus.halted), 32'h1);
    check("halt_valid", 32'(bus.if_id_valid), 32'h0);
    check("halt_instr", bus.if_id_instruction, 32'h0);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_pc_frozen", bus.imem_pc, 32'h10);
      check("halt_sticky", 32'(bus.halted), 32'h1);
    end
    check("halt_count", bus.fetch_count, 32'd7);

    // mid-run reset
    reset = 1'b1;
    tick();
    check("mrst_pc", bus.imem_pc, 32'h0);
    check("mrst_valid", 32'(bus.if_id_valid), 32'h0);
    check("mrst_instr", bus.if_id_instruction, 32'h0);
    check("mrst_pc4", bus.if_id_pc_plus4, 32'h0);
    check("mrst_halted", 32'(bus.halted), 32'h0);
    check("mrst_count", bus.fetch_count, 32'h0);
    reset = 1'b0; bus.branch_taken = 1'b0;
    push(32'h2000_0001, 32'h4);
    push(32'h2000_0002, 32'h8);
    tick(); tick();
    check("resume_pc", bus.imem_pc, 32'h8);
    check("resume_count", bus.fetch_count, 32'd2);

    bus.stall = 1'b1;
    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
